pixel_fb_writer: RTL and testbench

PIXEL_FB_WRITER -- requirements
Module: pixel_fb_writer

---
 rtl/pixel_fb_writer_if.sv | 27 ++
 rtl/pixel_fb_writer.sv | 154 +++++++++++++++
 tb/tb_pixel_fb_writer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_fb_writer_if.sv
// Pixel stream in, framebuffer write port out: the handshake bundle of pixel_fb_writer.
// The slave modport is the writer's view; the master modport drives pixels and accepts writes.
interface pixel_fb_writer_if #(
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned COLOR_W = 8
);
  logic               pix_valid;
  logic               pix_ready;
  logic [9:0]         pix_x;
  logic [9:0]         pix_y;
  logic [COLOR_W-1:0] pix_color;
  logic               pix_last;
  logic               fb_we;
  logic [ADDR_W-1:0]  fb_addr;
  logic [COLOR_W-1:0] fb_data;
  logic               fb_ready;

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_color, pix_last, fb_ready,
    output pix_ready, fb_we, fb_addr, fb_data
  );

  modport master (
    output pix_valid, pix_x, pix_y, pix_color, pix_last, fb_ready,
    input  pix_ready, fb_we, fb_addr, fb_data
  );
endinterface

// File: rtl/pixel_fb_writer.sv
// Buffers rasterised pixels in a small FIFO, clips off-screen ones, and issues one
// framebuffer write per visible pixel with a hold-until-ready write handshake.
module pixel_fb_writer #(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned COLOR_W    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  pixel_fb_writer_if.slave        bus,
  output logic [15:0]             clipped_cnt,
  output logic                    busy,
  output logic                    prim_done
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 10 + 10 + COLOR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_WRITE} state_t;

  state_t             r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [ENT_W-1:0]   w_head;
  logic               w_ready, w_push, w_pop;

  logic [9:0]         r_stg_x, r_stg_y;
  logic [COLOR_W-1:0] r_stg_color;
  logic               r_stg_last;

  logic               r_fb_we, w_fb_we_nxt;
  logic [ADDR_W-1:0]  r_fb_addr, w_fb_addr_nxt;
  logic [COLOR_W-1:0] r_fb_data, w_fb_data_nxt;
  logic [15:0]        r_clipped_cnt, w_clipped_nxt;
  logic               r_prim_done, w_prim_nxt;
  logic               r_busy, w_busy_nxt;

  logic [31:0]        w_addr_full;
  logic               w_off_screen;

  // Readiness looks only at the registered count, so a same-cycle pop never frees a slot.
  assign w_ready = (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push  = bus.pix_valid && w_ready;
  assign w_pop   = (r_state == S_IDLE) && (r_count != '0);
  assign w_head  = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.pix_x, bus.pix_y, bus.pix_color, bus.pix_last};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
    end
  end

  // Stage registers hold the pixel under evaluation/write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stg_x     <= '0;
      r_stg_y     <= '0;
      r_stg_color <= '0;
      r_stg_last  <= 1'b0;
    end else if (w_pop) begin
      {r_stg_x, r_stg_y, r_stg_color, r_stg_last} <= w_head;
    end
  end

  assign w_addr_full  = (32'(r_stg_y) * 32'(H_RES)) + 32'(r_stg_x);
  assign w_off_screen = (32'(r_stg_x) >= H_RES) || (32'(r_stg_y) >= V_RES);

  always_comb begin
    w_state_nxt   = r_state;
    w_fb_we_nxt   = r_fb_we;
    w_fb_addr_nxt = r_fb_addr;
    w_fb_data_nxt = r_fb_data;
    w_clipped_nxt = r_clipped_cnt;
    w_prim_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        if (w_off_screen) begin
          if (r_clipped_cnt != 16'hFFFF) w_clipped_nxt = r_clipped_cnt + 16'd1;
          w_prim_nxt  = r_stg_last;
          w_state_nxt = S_IDLE;
        end else begin
          w_fb_we_nxt   = 1'b1;
          w_fb_addr_nxt = ADDR_W'(w_addr_full);
          w_fb_data_nxt = r_stg_color;
          w_state_nxt   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (bus.fb_ready) begin
          w_fb_we_nxt = 1'b0;
          w_prim_nxt  = r_stg_last;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_fb_we       <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_data     <= '0;
      r_clipped_cnt <= '0;
      r_prim_done   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_fb_we       <= w_fb_we_nxt;
      r_fb_addr     <= w_fb_addr_nxt;
      r_fb_data     <= w_fb_data_nxt;
      r_clipped_cnt <= w_clipped_nxt;
      r_prim_done   <= w_prim_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign bus.pix_ready = w_ready;
  assign bus.fb_we     = r_fb_we;
  assign bus.fb_addr   = r_fb_addr;
  assign bus.fb_data   = r_fb_data;
  assign clipped_cnt   = r_clipped_cnt;
  assign busy          = r_busy;
  assign prim_done     = r_prim_done;
endmodule

// File: tb/tb_pixel_fb_writer.sv
// Bench for pixel_fb_writer: a queue-based pixel model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_pixel_fb_writer;
  localparam int unsigned H  = 640;
  localparam int unsigned V  = 480;
  localparam int unsigned D  = 8;
  localparam int unsigned AW = 19;
  localparam int unsigned CW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] clipped_cnt;
  logic        busy;
  logic        prim_done;

  pixel_fb_writer_if #(.ADDR_W(AW), .COLOR_W(CW)) bif ();

  pixel_fb_writer #(
    .H_RES(H), .V_RES(V), .FIFO_DEPTH(D), .ADDR_W(AW), .COLOR_W(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bif),
    .clipped_cnt(clipped_cnt),
    .busy       (busy),
    .prim_done  (prim_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] c;
    logic       last;
  } pix_t;

  function automatic bit off_screen(input pix_t p);
    return (32'(p.x) >= H) || (32'(p.y) >= V);
  endfunction

  // Model: pixels waiting in order, plus the one being serviced.
  pix_t        mq[$];
  pix_t        svc, inp;
  bit          svc_v, svc_wr, m_prim, acc, frdy;
  logic [15:0] m_clip;
  logic [15:0] preset_val = 16'h0;
  int          preset_req = 0;
  int          preset_ack = 0;

  initial begin : compare
    forever begin
      @(posedge clk);
      if (preset_req != preset_ack) begin
        m_clip     = preset_val;
        preset_ack = preset_req;
      end
      if (!reset) begin
        mq.delete();
        svc_v  = 1'b0;
        svc_wr = 1'b0;
        m_prim = 1'b0;
        m_clip = 16'h0;
      end else begin
        acc      = bif.pix_valid && (mq.size() < D);
        inp.x    = bif.pix_x;
        inp.y    = bif.pix_y;
        inp.c    = bif.pix_color;
        inp.last = bif.pix_last;
        frdy     = bif.fb_ready;
        m_prim   = 1'b0;
        if (svc_v && svc_wr) begin
          if (frdy) begin
            m_prim = svc.last;
            svc_v  = 1'b0;
            svc_wr = 1'b0;
          end
        end else if (svc_v) begin
          if (off_screen(svc)) begin
            if (m_clip != 16'hFFFF) m_clip = m_clip + 16'd1;
            m_prim = svc.last;
            svc_v  = 1'b0;
          end else begin
            svc_wr = 1'b1;
          end
        end else if (mq.size() != 0) begin
          svc   = mq.pop_front();
          svc_v = 1'b1;
        end
        if (acc) mq.push_back(inp);
      end
      #1;
      chk("pix_ready", 32'(bif.pix_ready), 32'(mq.size() < D));
      chk("busy", 32'(busy), 32'((mq.size() != 0) || svc_v));
      chk("fb_we", 32'(bif.fb_we), 32'(svc_v && svc_wr));
      chk("clipped_cnt", 32'(clipped_cnt), 32'(m_clip));
      chk("prim_done", 32'(prim_done), 32'(m_prim));
      if (svc_v && svc_wr) begin
        chk("fb_addr", 32'(bif.fb_addr), (32'(svc.y) * H) + 32'(svc.x));
        chk("fb_data", 32'(bif.fb_data), 32'(svc.c));
      end
      if (!reset) begin
        chk("rst_fb_addr", 32'(bif.fb_addr), 32'(0));
        chk("rst_fb_data", 32'(bif.fb_data), 32'(0));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge, valid still high.
  task automatic send(input int x, input int y, input int c, input bit last);
    bif.pix_x     = 10'(x);
    bif.pix_y     = 10'(y);
    bif.pix_color = 8'(c);
    bif.pix_last  = last;
    bif.pix_valid = 1'b1;
    for (int k = 0; k < 400 && !bif.pix_ready; k++) @(negedge clk);
    if (!bif.pix_ready) chk("send_accept_timeout", 32'(bif.pix_ready), 32'(1));
    @(negedge clk);
  endtask

  task automatic stop_in();
    bif.pix_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 600 && busy; k++) @(negedge clk);
    chk("wait_idle", 32'(busy), 32'(0));
  endtask

  initial begin : stim
    bit saw_we;
    reset         = 1'b0;
    bif.pix_valid = 1'b0;
    bif.pix_x     = '0;
    bif.pix_y     = '0;
    bif.pix_color = '0;
    bif.pix_last  = 1'b0;
    bif.fb_ready  = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_pix_ready", 32'(bif.pix_ready), 32'(1));
    chk("reset_fb_we", 32'(bif.fb_we), 32'(0));
    chk("reset_clipped", 32'(clipped_cnt), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_prim", 32'(prim_done), 32'(0));
    reset = 1'b1;
    @(negedge clk);

    // Single pixel latency and address
    send(3, 2, 'hA5, 1'b1);
    stop_in();
    chk("single_we_n0", 32'(bif.fb_we), 32'(0));
    @(negedge clk);
    chk("single_we_n1", 32'(bif.fb_we), 32'(0));
    @(negedge clk);
    chk("single_we_n2", 32'(bif.fb_we), 32'(1));
    chk("single_addr", 32'(bif.fb_addr), 32'd1283);
    chk("single_data", 32'(bif.fb_data), 32'hA5);
    @(negedge clk);
    chk("single_prim", 32'(prim_done), 32'(1));
    chk("single_we_off", 32'(bif.fb_we), 32'(0));
    @(negedge clk);
    chk("single_prim_off", 32'(prim_done), 32'(0));
    wait_idle();

    // Clip boundaries
    send(640, 0, 1, 1'b0);
    send(0, 480, 2, 1'b0);
    send(639, 479, 'h3C, 1'b0);
    stop_in();
    for (int k = 0; k < 30 && !bif.fb_we; k++) @(negedge clk);
    chk("edge_we", 32'(bif.fb_we), 32'(1));
    chk("edge_addr", 32'(bif.fb_addr), 32'd307199);
    chk("edge_data", 32'(bif.fb_data), 32'h3C);
    wait_idle();
    chk("edge_clipped", 32'(clipped_cnt), 32'd2);

    // Clipped last pixel still ends the primitive
    send(700, 5, 'h11, 1'b1);
    stop_in();
    @(negedge clk);
    @(negedge clk);
    chk("cliplast_prim", 32'(prim_done), 32'(1));
    chk("cliplast_cnt", 32'(clipped_cnt), 32'd3);
    chk("cliplast_we", 32'(bif.fb_we), 32'(0));
    wait_idle();

    // Backpressure: one pixel in service plus eight buffered fills the writer
    bif.fb_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(i, 1, 16 + i, 1'b0);
    bif.pix_x     = 10'd9;
    bif.pix_color = 8'd25;
    bif.pix_last  = 1'b1;
    chk("full_ready", 32'(bif.pix_ready), 32'(0));
    chk("full_we", 32'(bif.fb_we), 32'(1));
    chk("full_addr", 32'(bif.fb_addr), 32'd640);
    repeat (3) @(negedge clk);
    chk("full_ready_hold", 32'(bif.pix_ready), 32'(0));
    chk("full_addr_hold", 32'(bif.fb_addr), 32'd640);
    bif.fb_ready = 1'b1;
    send(9, 1, 25, 1'b1);
    stop_in();
    wait_idle();

    // Clipped counter saturation from a preset near the top
    force dut.r_clipped_cnt = 16'hFFFD;
    preset_val = 16'hFFFD;
    preset_req++;
    @(negedge clk);
    release dut.r_clipped_cnt;
    send(800, 0, 1, 1'b0);
    send(0, 500, 2, 1'b0);
    send(1023, 1023, 3, 1'b1);
    stop_in();
    wait_idle();
    chk("sat_clipped", 32'(clipped_cnt), 32'hFFFF);

    // Reset during a held write with four pixels queued
    bif.fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(10 + i, 7, 'h40 + i, 1'b0);
    stop_in();
    chk("rstw_we_before", 32'(bif.fb_we), 32'(1));
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rstw_we", 32'(bif.fb_we), 32'(0));
    chk("rstw_ready", 32'(bif.pix_ready), 32'(1));
    chk("rstw_busy", 32'(busy), 32'(0));
    chk("rstw_clipped", 32'(clipped_cnt), 32'(0));
    @(negedge clk);
    @(negedge clk);
    bif.fb_ready = 1'b1;
    reset = 1'b1;
    saw_we = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_we = saw_we | bif.fb_we;
    end
    chk("rstw_no_we_after", 32'(saw_we), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
